// File: rtl/adc0809_pkg.sv
// Shared types and constants for the ADC0809 scan sequencer.
package adc0809_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        WAIT_FALL,
        WAIT_RISE,
        READ,
        NEXT
    } state_e;

    localparam int SETUP_W     = 2;
    localparam int SYNC_STAGES = 2;
    localparam int ADC_W       = 8;
    localparam int ADDR_W      = 3;
    localparam int ACC_W       = 10;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adc_clk_div.sv
// Free-running 50% duty converter clock: toggles every CLK_DIV/2 system clocks.
module adc_clk_div #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic reset,
    output logic adc_clk
);

    localparam int HALF = CLK_DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt_q;
    logic          adc_clk_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            adc_clk_q <= 1'b0;
        end else if (cnt_q == CW'(HALF - 1)) begin
            cnt_q     <= '0;
            adc_clk_q <= ~adc_clk_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign adc_clk = adc_clk_q;

endmodule

// File: rtl/adc0809_scan.sv
// Round-robin conversion sequencer for an ADC0809-style converter.
// Define ADC_AVG4_EN to average four consecutive conversions per channel.
module adc0809_scan
    import adc0809_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter int NUM_CH  = 1,
    parameter int PULSE_W = 10,
    parameter int OE_W    = 4,
    parameter int EOC_TO  = 2000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              eoc,
    input  logic [ADC_W-1:0]  result,
    output logic              adc_clk,
    output logic [ADDR_W-1:0] addr,
    output logic              ale,
    output logic              start,
    output logic              out_en,
    output logic [ADC_W-1:0]  data_out,
    output logic [ADDR_W-1:0] data_ch,
    output logic              data_valid,
    output logic              timeout_err
);

    localparam int CNT_MAX = max2(max2(EOC_TO, PULSE_W), max2(OE_W, SETUP_W));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [ADDR_W-1:0]      ch_q, ch_d, addr_q, data_ch_q;
    logic [ADC_W-1:0]       data_out_q;
    logic                   ale_q, start_q, out_en_q, data_valid_q, timeout_q;
    logic [SYNC_STAGES-1:0] eoc_sync_q;
    logic                   eoc_s;

    assign eoc_s = eoc_sync_q[SYNC_STAGES-1];
    assign ch_d  = (ch_q == ADDR_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;

`ifdef ADC_AVG4_EN
    logic [ACC_W-1:0] acc_q, sum_d;
    logic [1:0]       avg_cnt_q;
    assign sum_d = acc_q + ACC_W'(result);
`endif

    adc_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk     (clk),
        .reset   (reset),
        .adc_clk (adc_clk)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ch_q         <= '0;
            addr_q       <= '0;
            ale_q        <= 1'b0;
            start_q      <= 1'b0;
            out_en_q     <= 1'b0;
            data_out_q   <= '0;
            data_ch_q    <= '0;
            data_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            eoc_sync_q   <= '1;
`ifdef ADC_AVG4_EN
            acc_q        <= '0;
            avg_cnt_q    <= '0;
`endif
        end else begin
            eoc_sync_q   <= {eoc_sync_q[SYNC_STAGES-2:0], eoc};
            data_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q <= SETUP;
                    cnt_q   <= '0;
                    addr_q  <= ch_q;
                end
                SETUP: begin
                    addr_q <= ch_q;
                    if (cnt_q == CNT_W'(SETUP_W - 1)) begin
                        state_q <= PULSE;
                        cnt_q   <= '0;
                        ale_q   <= 1'b1;
                        start_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_q == CNT_W'(PULSE_W - 1)) begin
                        state_q <= WAIT_FALL;
                        cnt_q   <= '0;
                        ale_q   <= 1'b0;
                        start_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                // Both waits share one timeout counter, cleared on every state change.
                WAIT_FALL, WAIT_RISE: begin
                    cnt_q <= '0;
                    if (state_q == WAIT_FALL && !eoc_s) begin
                        state_q <= WAIT_RISE;
                    end else if (state_q == WAIT_RISE && eoc_s) begin
                        state_q  <= READ;
                        out_en_q <= 1'b1;
                    end else if (cnt_q == CNT_W'(EOC_TO - 1)) begin
                        state_q   <= SETUP;
                        timeout_q <= 1'b1;
`ifdef ADC_AVG4_EN
                        acc_q     <= '0;
                        avg_cnt_q <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                READ: begin
                    if (cnt_q == CNT_W'(OE_W - 1)) begin
                        cnt_q    <= '0;
                        out_en_q <= 1'b0;
`ifdef ADC_AVG4_EN
                        if (avg_cnt_q == 2'd3) begin
                            data_out_q   <= sum_d[ACC_W-1:2];
                            data_ch_q    <= addr_q;
                            data_valid_q <= 1'b1;
                            acc_q        <= '0;
                            avg_cnt_q    <= '0;
                            state_q      <= NEXT;
                        end else begin
                            acc_q     <= sum_d;
                            avg_cnt_q <= avg_cnt_q + 1'b1;
                            state_q   <= SETUP;
                        end
`else
                        data_out_q   <= result;
                        data_ch_q    <= addr_q;
                        data_valid_q <= 1'b1;
                        state_q      <= NEXT;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                NEXT: begin
                    ch_q    <= ch_d;
                    addr_q  <= ch_d;
                    cnt_q   <= '0;
                    state_q <= SETUP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addr        = addr_q;
    assign ale         = ale_q;
    assign start       = start_q;
    assign out_en      = out_en_q;
    assign data_out    = data_out_q;
    assign data_ch     = data_ch_q;
    assign data_valid  = data_valid_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_adc0809_scan.sv
// Bench for adc0809_scan: three instances (defaults, fast 3-channel scan, EOC stuck high).
module tb_adc0809_scan;

`ifdef ADC_AVG4_EN
    localparam int K = 4;
`else
    localparam int K = 1;
`endif
    localparam int DIV_A  = 50;
    localparam int DIV_B  = 4;
    localparam int FALL_B = 8 * DIV_B;
    localparam int RISE_B = 64 * DIV_B;
    localparam int NR     = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instance A: default timing, single channel ----------------
    logic       reset_a = 1'b1, eoc_a = 1'b1;
    logic       adc_clk_a, ale_a, start_a, out_en_a, data_valid_a, timeout_err_a;
    logic [2:0] addr_a, data_ch_a;
    logic [7:0] data_out_a;

    // Converter needs 64 adc_clk periods to finish, so the EOC timeout is widened here.
    adc0809_scan #(.CLK_DIV(DIV_A), .NUM_CH(1), .PULSE_W(10), .OE_W(4), .EOC_TO(4000)) dut_a (
        .clk(clk), .reset(reset_a), .eoc(eoc_a), .result(8'hA5),
        .adc_clk(adc_clk_a), .addr(addr_a), .ale(ale_a), .start(start_a), .out_en(out_en_a),
        .data_out(data_out_a), .data_ch(data_ch_a), .data_valid(data_valid_a),
        .timeout_err(timeout_err_a)
    );

    initial begin
        forever begin
            @(posedge start_a);
            repeat (8 * DIV_A) @(posedge clk);
            eoc_a <= 1'b0;
            repeat (64 * DIV_A) @(posedge clk);
            eoc_a <= 1'b1;
        end
    end

    // ---------------- instance B: fast adc_clk, three channels ----------------
    logic       reset_b = 1'b1, eoc_b = 1'b1;
    logic [7:0] res_b = 8'h00;
    logic       adc_clk_b, ale_b, start_b, out_en_b, data_valid_b, timeout_err_b;
    logic [2:0] addr_b, data_ch_b;
    logic [7:0] data_out_b;

    adc0809_scan #(.CLK_DIV(DIV_B), .NUM_CH(3), .PULSE_W(10), .OE_W(4), .EOC_TO(2000)) dut_b (
        .clk(clk), .reset(reset_b), .eoc(eoc_b), .result(res_b),
        .adc_clk(adc_clk_b), .addr(addr_b), .ale(ale_b), .start(start_b), .out_en(out_en_b),
        .data_out(data_out_b), .data_ch(data_ch_b), .data_valid(data_valid_b),
        .timeout_err(timeout_err_b)
    );

    // Converter model: each START rising edge (re)arms the EOC sequence and pops the next result.
    logic [7:0] res_q_b[$];
    logic [2:0] addr_log_b[$];
    int         b_cnt = 0;
    bit         b_busy = 1'b0;
    logic       start_b_d = 1'b0;
    int         to_b_cnt = 0;

    always @(posedge clk) begin
        start_b_d <= start_b;
        if (start_b && !start_b_d) begin
            b_busy <= 1'b1;
            b_cnt  <= 0;
            eoc_b  <= 1'b1;
            addr_log_b.push_back(addr_b);
            if (res_q_b.size() > 0) res_b <= res_q_b.pop_front();
            else                    res_b <= 8'h3C;
        end else if (b_busy) begin
            b_cnt <= b_cnt + 1;
            if (b_cnt == FALL_B - 1) eoc_b <= 1'b0;
            if (b_cnt == FALL_B + RISE_B - 1) begin
                eoc_b  <= 1'b1;
                b_busy <= 1'b0;
            end
        end
    end

    always @(negedge clk) if (timeout_err_b) to_b_cnt <= to_b_cnt + 1;

    // ---------------- instance C: EOC stuck high ----------------
    logic       reset_c = 1'b1;
    logic       adc_clk_c, ale_c, start_c, out_en_c, data_valid_c, timeout_err_c;
    logic [2:0] addr_c, data_ch_c;
    logic [7:0] data_out_c;
    int         dv_c_cnt = 0;

    adc0809_scan #(.CLK_DIV(50), .NUM_CH(3), .PULSE_W(10), .OE_W(4), .EOC_TO(2000)) dut_c (
        .clk(clk), .reset(reset_c), .eoc(1'b1), .result(8'h77),
        .adc_clk(adc_clk_c), .addr(addr_c), .ale(ale_c), .start(start_c), .out_en(out_en_c),
        .data_out(data_out_c), .data_ch(data_ch_c), .data_valid(data_valid_c),
        .timeout_err(timeout_err_c)
    );

    always @(negedge clk) if (data_valid_c) dv_c_cnt <= dv_c_cnt + 1;

    // ---------------- test threads ----------------
    typedef struct {
        logic [3:0][7:0] r;
        logic [2:0]      ch;
        logic [7:0]      exp;
    } vec_t;

    task automatic run_a();
        repeat (3) @(negedge clk);
        check("a_reset_outputs", 32'({adc_clk_a, addr_a, ale_a, start_a, out_en_a, data_out_a,
                                      data_ch_a, data_valid_a, timeout_err_a}), 32'd0);
        reset_a = 1'b0;
        fork
            begin : clk_meas
                int lo = 0, hi = 0, lo2 = 0;
                while (adc_clk_a == 1'b0 && lo < 100) begin lo++; @(negedge clk); end
                while (adc_clk_a == 1'b1 && hi < 100) begin hi++; @(negedge clk); end
                while (adc_clk_a == 1'b0 && lo2 < 100) begin lo2++; @(negedge clk); end
                check("a_adc_clk_first_low", 32'(lo), 32'd25);
                check("a_adc_clk_high", 32'(hi), 32'd25);
                check("a_adc_clk_low", 32'(lo2), 32'd25);
                check("a_adc_clk_period", 32'(hi + lo2), 32'd50);
            end
            begin : seq_meas
                int t = 0, w = 0, ws = 0, oe = 0;
                while (!ale_a && t < 100) begin t++; @(negedge clk); end
                check("a_ale_seen", 32'(ale_a), 32'd1);
                check("a_addr_pulse", 32'(addr_a), 32'd0);
                while (ale_a && w < 100) begin w++; if (start_a) ws++; @(negedge clk); end
                check("a_ale_width", 32'(w), 32'd10);
                check("a_start_width", 32'(ws), 32'd10);
                t = 0;
                while (!out_en_a && t < 5000) begin t++; @(negedge clk); end
                check("a_out_en_seen", 32'(out_en_a), 32'd1);
                while (out_en_a && oe < 100) begin oe++; @(negedge clk); end
                check("a_out_en_width", 32'(oe), 32'd4);
                t = 0;
                while (!data_valid_a && t < 20000) begin t++; @(negedge clk); end
                check("a_dv_seen", 32'(data_valid_a), 32'd1);
                check("a_data_out", 32'(data_out_a), 32'hA5);
                check("a_data_ch", 32'(data_ch_a), 32'd0);
                $display("a: ch %0d data %02h", data_ch_a, data_out_a);
                @(negedge clk);
                check("a_dv_one_cycle", 32'(data_valid_a), 32'd0);
                check("a_data_held", 32'(data_out_a), 32'hA5);
            end
        join
    endtask

    task automatic wait_dv_b(input int budget);
        int t = 0;
        while (!data_valid_b && t < budget) begin t++; @(negedge clk); end
    endtask

    task automatic run_b();
        vec_t       tbl[4];
        logic [7:0] exp_d[$];
        int         sum, v, t;
        tbl[0] = '{32'h41302010, 3'd0, 8'h28};
`ifdef ADC_AVG4_EN
        tbl[1] = '{32'h11111111, 3'd1, 8'h11};
        tbl[2] = '{32'h12121212, 3'd2, 8'h12};
        tbl[3] = '{32'h10101010, 3'd0, 8'h10};
`else
        tbl[0].exp = 8'h10;
        tbl[1] = '{32'h00000011, 3'd1, 8'h11};
        tbl[2] = '{32'h00000012, 3'd2, 8'h12};
        tbl[3] = '{32'h00000010, 3'd0, 8'h10};
`endif
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < K; k++) res_q_b.push_back(tbl[i].r[k]);
        // Reference: each output is the floor mean of the K conversions that feed it.
        for (int i = 0; i < NR; i++) begin
            sum = 0;
            for (int k = 0; k < K; k++) begin
                v = int'($urandom_range(255, 0));
                res_q_b.push_back(8'(v));
                sum += v;
            end
            exp_d.push_back(8'(sum / K));
        end

        repeat (3) @(negedge clk);
        reset_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_dv_b(3000 * K);
            check("b_tbl_dv_seen", 32'(data_valid_b), 32'd1);
            check("b_tbl_data", 32'(data_out_b), 32'(tbl[i].exp));
            check("b_tbl_ch", 32'(data_ch_b), 32'(tbl[i].ch));
            $display("b vec %0d: ch %0d data %02h", i, data_ch_b, data_out_b);
            @(negedge clk);
        end
        for (int i = 0; i < NR; i++) begin
            wait_dv_b(3000 * K);
            check("b_rnd_dv_seen", 32'(data_valid_b), 32'd1);
            check("b_rnd_data", 32'(data_out_b), 32'(exp_d[i]));
            check("b_rnd_ch", 32'((4 + i) % 3), 32'(data_ch_b));
            $display("b vec %0d: ch %0d data %02h", 4 + i, data_ch_b, data_out_b);
            @(negedge clk);
        end
        check("b_addr_log_len", 32'(addr_log_b.size() >= (4 + NR) * K), 32'd1);
        for (int j = 0; j < (4 + NR) * K && j < addr_log_b.size(); j++)
            check("b_addr_seq", 32'(addr_log_b[j]), 32'((j / K) % 3));
        check("b_no_timeouts", 32'(to_b_cnt), 32'd0);

        // Reset three cycles into a PULSE on a nonzero channel.
        t = 0;
        while (!(ale_b && addr_b != 3'd0) && t < 6000 * K) begin t++; @(negedge clk); end
        check("b_pulse_found", 32'(ale_b), 32'd1);
        repeat (2) @(negedge clk);
        check("b_ale_before_reset", 32'(ale_b), 32'd1);
        reset_b = 1'b1;
        @(negedge clk);
        check("b_reset_outputs", 32'({adc_clk_b, addr_b, ale_b, start_b, out_en_b, data_out_b,
                                      data_ch_b, data_valid_b, timeout_err_b}), 32'd0);
        reset_b = 1'b0;
        t = 0;
        while (!ale_b && t < 100) begin t++; @(negedge clk); end
        check("b_restart_pulse", 32'(ale_b), 32'd1);
        check("b_restart_addr", 32'(addr_b), 32'd0);
        wait_dv_b(3000 * K);
        check("b_restart_dv", 32'(data_valid_b), 32'd1);
        check("b_restart_ch", 32'(data_ch_b), 32'd0);
        check("b_restart_data", 32'(data_out_b), 32'h3C);
        $display("b restart: ch %0d data %02h", data_ch_b, data_out_b);
    endtask

    task automatic run_c();
        int t = 0;
        repeat (3) @(negedge clk);
        reset_c = 1'b0;
        while (!ale_c && t < 100) begin t++; @(negedge clk); end
        t = 0;
        while (ale_c && t < 100) begin t++; @(negedge clk); end
        t = 0;
        while (!timeout_err_c && t < 2100) begin t++; @(negedge clk); end
        check("c_timeout_delay", 32'(t), 32'd2000);
        $display("c: timeout after %0d cycles", t);
        @(negedge clk);
        check("c_timeout_one_cycle", 32'(timeout_err_c), 32'd0);
        t = 0;
        while (!ale_c && t < 100) begin t++; @(negedge clk); end
        check("c_pulse_reissued", 32'(ale_c), 32'd1);
        check("c_same_addr", 32'(addr_c), 32'd0);
        check("c_no_data_valid", 32'(dv_c_cnt), 32'd0);
        check("c_data_unchanged", 32'(data_out_c), 32'd0);
    endtask

    initial begin
        fork
            run_a();
            run_b();
            run_c();
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got no completion, expected finish within 90000 cycles");
        $fatal(1);
    end

endmodule
